alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 12, operand/result width; SHALL match the alu datapath width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  sequencer accepts instruction this cycle.
REQ-006 in_opcode  input  3  ALU opcode: 0 add, 2 mul, 3 right-shift, 5 and; all others unsupported.
REQ-007 in_op_a  input  WIDTH  operand A (ignored when in_chain=1).
REQ-008 in_op_b  input  WIDTH  operand B.
REQ-009 in_chain  input  1  1 = use accumulator as operand A.
REQ-010 acc_clr  input  1  clear accumulator request.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  WIDTH  result.
REQ-014 out_err  output  1  result came from unsupported opcode.
REQ-015 op_count  output  16  completed-operation counter.

Function
REQ-016 FSM states IDLE, ISSUE, HOLD; SHALL leave IDLE only on in_valid & in_ready.
REQ-017 IDLE: in_ready=1, out_valid=0; on accept, latch opcode, operand A (accumulator if in_chain, else in_op_a), in_op_b into registers; next state ISSUE.
REQ-018 ISSUE: registered opcode/operands SHALL drive the alu; alu result captured into out_data and accumulator at end of cycle; out_err set if opcode not in {0,2,3,5}; next state HOLD.
REQ-019 HOLD: out_valid=1; out_data, out_err SHALL stay stable until out_valid & out_ready; on handshake next state IDLE, op_count increments.
REQ-020 in_ready SHALL be 0 in ISSUE and HOLD.
REQ-021 Latency: accept at cycle N -> out_valid high at cycle N+2; minimum 3 cycles per instruction with out_ready held 1.
REQ-022 Result SHALL be alu output unmodified: add mod 2^WIDTH, mul low WIDTH bits, shift A>>B, bitwise and; unsupported opcode -> 0.
REQ-023 op_count SHALL saturate at 0xFFFF, not wrap.
REQ-024 acc_clr SHALL act only in IDLE; if asserted with an accepted in_chain=1 instruction, operand A SHALL be 0 and the accumulator then takes the new result.
REQ-025 acc_clr in ISSUE/HOLD SHALL be ignored.
REQ-026 Unsupported-opcode results SHALL still update the accumulator (to 0) and count as completed.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, accumulator 0, out_data 0, out_err 0, op_count 0, out_valid 0, in_ready 1 in the following cycle, from any state.
REQ-028 An instruction in flight at reset SHALL be discarded with no output handshake.

Structure
REQ-029 Shared package SHALL hold the opcode constants (OP_ADD=0, OP_MUL=2, OP_RSH=3, OP_AND=5) and the FSM state encoding.
REQ-030 Exactly one sub-module: the existing alu, instantiated once, driven only from registered operand/opcode signals.

Verification
REQ-031 Add: accept {0, 0x0FF, 0x001}, out_ready=1 -> out_valid at N+2, out_data=0x100, out_err=0, op_count=1.
REQ-032 Wrap/mul: {0, 0xFFF, 0x002} -> 0x001; {2, 0x012, 0x010} -> 0x120; {2, 0x040, 0x040} -> 0x000.
REQ-033 Unsupported: opcode 1, A=0x123, B=0x456 -> out_data=0x000, out_err=1, op_count increments.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data/out_err stable, in_ready=0, in_valid held ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Chain: acc_clr=1 with chained {0, -, 0x005} -> 0x005; chained {5, -, 0x00C} -> 0x004; chained {3, -, 0x001} -> 0x002.
REQ-036 Reset mid-HOLD: rst_n=0 one cycle while out_valid=1 -> next cycle out_valid=0, in_ready=1, op_count=0, accumulator 0.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
//   Shared definitions for the ALU sequencer: opcode encodings, FSM state
//   encoding and a helper that classifies opcodes as supported or not.
package alu_sequencer_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_RSH = 3'd3;
  localparam logic [2:0] OP_AND = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_RSH) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// alu_sequencer_alu
//   Purely combinational ALU.
//   Ports:
//     i_opcode  - operation select (add, mul, right-shift, and)
//     i_a, i_b  - operands, WIDTH bits
//     o_result  - result, WIDTH bits (0 for unsupported opcodes)
//     o_err     - 1 when i_opcode is unsupported
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [2:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  logic [2*WIDTH-1:0] w_prod;

  // Full-width product; only the low half is returned.
  assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_opcode)
      OP_ADD:  o_result = i_a + i_b;
      OP_MUL:  o_result = w_prod[WIDTH-1:0];
      OP_RSH:  o_result = i_a >> i_b;
      OP_AND:  o_result = i_a & i_b;
      default: o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accepts one ALU instruction at a time, runs it through the ALU from
//   registered operands, and holds the result until downstream takes it.
//   Keeps an accumulator (last result) usable as operand A via in_chain.
//   Ports:
//     clk, rst_n          - clock, synchronous active-low reset
//     in_valid/in_ready   - instruction handshake
//     in_opcode, in_op_a, in_op_b, in_chain, acc_clr - instruction fields
//     out_valid/out_ready - result handshake
//     out_data, out_err   - result and unsupported-opcode flag
//     op_count            - saturating count of completed instructions
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opcode,
  input  logic [WIDTH-1:0] in_op_a,
  input  logic [WIDTH-1:0] in_op_b,
  input  logic             in_chain,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [15:0]      op_count
);

  state_t           r_state;
  logic [2:0]       r_opcode;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic [15:0]      r_op_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_err;

  alu_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .i_opcode (r_opcode),
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .o_result (w_alu_res),
    .o_err    (w_alu_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_opcode    <= OP_ADD;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_op_count  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (acc_clr) r_acc <= '0;
          if (in_valid && r_in_ready) begin
            r_opcode   <= in_opcode;
            // A clear in the same cycle as a chained accept zeroes operand A.
            r_op_a     <= in_chain ? (acc_clr ? '0 : r_acc) : in_op_a;
            r_op_b     <= in_op_b;
            r_in_ready <= 1'b0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Unsupported opcodes yield 0 from the ALU and still land in the
          // accumulator.
          r_out_data  <= w_alu_res;
          r_out_err   <= w_alu_err;
          r_acc       <= w_alu_res;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign op_count  = r_op_count;

endmodule
